// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter: FSM states, requester indices,
// one-hot grant codes, default timing constants and the round-robin pick.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_ALERT,
    ST_OWN_RR
  } state_e;

  localparam int ALERT = 0;
  localparam int SCORE = 1;
  localparam int TIMER = 2;

  localparam logic [2:0] GNT_NONE  = 3'b000;
  localparam logic [2:0] GNT_ALERT = 3'b001;
  localparam logic [2:0] GNT_SCORE = 3'b010;
  localparam logic [2:0] GNT_TIMER = 3'b100;

  localparam logic [23:0] HOLD_CYCLES_DEF  = 24'd1000000;
  localparam logic [23:0] BLINK_CYCLES_DEF = 24'd6000000;

  // rr_req[0] is the score request, rr_req[1] the timer request.
  function automatic logic [2:0] rr_pick(input logic [1:0] rr_req, input logic last_timer);
    if (rr_req == 2'b11) return last_timer ? GNT_SCORE : GNT_TIMER;
    if (rr_req[1])       return GNT_TIMER;
    if (rr_req[0])       return GNT_SCORE;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Loadable 24-bit down-counter that saturates at zero; load wins over decrement.
module disp_hold_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [23:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 24'd1;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Three-way display arbiter: alert preempts, score/timer share by hold-time round-robin.
// Optional BLANK blinking while alert owns the display: define DISP_ARB_BLINK_EN.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter logic [23:0] HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter logic [23:0] BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  REQ,
  input  logic [31:0] DATA0,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic [2:0]  GNT,
  output logic [31:0] DISP_VALUE,
  output logic        BLANK
);

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [31:0] disp_q, disp_d;
  logic        blank_q, blank_d;
  logic        last_timer_q, last_timer_d;
  logic        hold_load, hold_dec, hold_zero;
  logic        own_timer, own_req, other_req;

  assign own_timer = gnt_q[TIMER];
  assign own_req   = own_timer ? REQ[TIMER] : REQ[SCORE];
  assign other_req = own_timer ? REQ[SCORE] : REQ[TIMER];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    hold_load    = 1'b0;
    last_timer_d = last_timer_q;
    if (REQ[ALERT]) begin
      state_d = ST_OWN_ALERT;
      gnt_d   = GNT_ALERT;
    end else begin
      unique case (state_q)
        ST_OWN_RR: begin
          // Yield only when the owner leaves, or its hold expired and the peer waits.
          if (!own_req || (hold_zero && other_req)) begin
            if (other_req) begin
              gnt_d     = own_timer ? GNT_SCORE : GNT_TIMER;
              hold_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              gnt_d   = GNT_NONE;
            end
          end
        end
        default: begin
          if (|REQ[TIMER:SCORE]) begin
            state_d   = ST_OWN_RR;
            gnt_d     = rr_pick(REQ[TIMER:SCORE], last_timer_q);
            hold_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = GNT_NONE;
          end
        end
      endcase
    end
    if (hold_load) last_timer_d = gnt_d[TIMER];
  end

  assign hold_dec = (state_q == ST_OWN_RR);

  disp_hold_timer u_hold (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (hold_load),
    .load_val (HOLD_CYCLES - 24'd1),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  always_comb begin
    unique case (gnt_d)
      GNT_ALERT: disp_d = DATA0;
      GNT_SCORE: disp_d = DATA1;
      GNT_TIMER: disp_d = DATA2;
      default:   disp_d = disp_q;
    endcase
  end

`ifdef DISP_ARB_BLINK_EN
  logic blink_load, blink_dec, blink_zero;

  always_comb begin
    blank_d    = (state_d == ST_IDLE);
    blink_load = 1'b0;
    blink_dec  = 1'b0;
    if (state_d == ST_OWN_ALERT) begin
      if (state_q != ST_OWN_ALERT) begin
        blank_d    = 1'b0;
        blink_load = 1'b1;
      end else if (blink_zero) begin
        blank_d    = ~blank_q;
        blink_load = 1'b1;
      end else begin
        blank_d    = blank_q;
        blink_dec  = 1'b1;
      end
    end
  end

  disp_hold_timer u_blink (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (blink_load),
    .load_val (BLINK_CYCLES - 24'd1),
    .dec      (blink_dec),
    .zero     (blink_zero)
  );
`else
  logic unused_blink_cycles;
  assign unused_blink_cycles = ^BLINK_CYCLES;
  assign blank_d = (state_d == ST_IDLE);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_NONE;
      disp_q       <= '0;
      blank_q      <= 1'b1;
      last_timer_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      disp_q       <= disp_d;
      blank_q      <= blank_d;
      last_timer_q <= last_timer_d;
    end
  end

  assign GNT        = gnt_q;
  assign DISP_VALUE = disp_q;
  assign BLANK      = blank_q;

endmodule
